// File: rtl/posit16_pkg.sv
// Shared types and constants for the 16-bit posit decode/encode datapath.
package posit16_pkg;

  localparam int N      = 16;
  localparam int BODY_W = N - 1;
  localparam int K_W    = 5;
  localparam int RLEN_W = 4;

  localparam logic [RLEN_W-1:0] RUN_MAX = 4'd15;
  localparam logic [N-1:0]      P_ZERO  = 16'h0000;
  localparam logic [N-1:0]      P_NAR   = 16'h8000;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // A run of ones encodes k = run-1; a run of zeros encodes k = -run.
  function automatic logic [K_W-1:0] regime_k(input logic r0, input logic [RLEN_W-1:0] run);
    logic [K_W-1:0] r;
    r = {1'b0, run};
    return r0 ? (r - 5'd1) : (5'd0 - r);
  endfunction

  function automatic logic [RLEN_W-1:0] regime_len(input logic [RLEN_W-1:0] run);
    return (run == RUN_MAX) ? RUN_MAX : (run + 4'd1);
  endfunction

endpackage

// File: rtl/posit16_abs.sv
// Two's-complement magnitude of a posit word; NaR (0x8000) maps onto itself.
module posit16_abs
  import posit16_pkg::*;
(
  input  logic [N-1:0] p,
  output logic [N-1:0] mag
);

  assign mag = p[N-1] ? (~p + 16'd1) : p;

endmodule

// File: rtl/regdec16.sv
// Posit<16,es> regime decoder: serially scans the regime run, one bit per cycle.
// Optional macro REGDEC16_SPECIAL_EN short-circuits zero and NaR words.
module regdec16
  import posit16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      p_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [K_W-1:0]    k_out,
  output logic [RLEN_W-1:0] rlen_out,
  output logic [BODY_W-1:0] rem_out,
  output logic              zero_out,
  output logic              nar_out
);

  state_t              state;
  logic [N-1:0]        mag;
  logic [BODY_W-1:0]   body;
  logic [BODY_W-1:0]   sh;
  logic [RLEN_W-1:0]   run;
  logic                r0;
  logic                sign_q;
  logic                scan_end;
  logic                unused_mag_msb;

  posit16_abs u_abs (
    .p   (p_in),
    .mag (mag)
  );

  // The magnitude MSB is set only for NaR, whose body bits are all zero.
  assign unused_mag_msb = mag[N-1];
  assign body           = mag[BODY_W-1:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign scan_end  = (run == RUN_MAX) || (sh[BODY_W-1] != r0);

`ifdef REGDEC16_SPECIAL_EN
  logic zero_q;
  logic nar_q;
  assign zero_out = zero_q;
  assign nar_out  = nar_q;
`else
  assign zero_out = 1'b0;
  assign nar_out  = 1'b0;
`endif

  // NOTE: all state here uses <= so every register samples pre-edge values;
  // mixing in = would make the shift and run counter order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      r0       <= 1'b0;
      run      <= '0;
      sh       <= '0;
      sign_out <= 1'b0;
      k_out    <= '0;
      rlen_out <= '0;
      rem_out  <= '0;
`ifdef REGDEC16_SPECIAL_EN
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef REGDEC16_SPECIAL_EN
            if (p_in == P_ZERO || p_in == P_NAR) begin
              sign_out <= p_in[N-1];
              k_out    <= '0;
              rlen_out <= '0;
              rem_out  <= '0;
              zero_q   <= (p_in == P_ZERO);
              nar_q    <= (p_in == P_NAR);
              state    <= DONE;
            end else
`endif
            begin
              sign_q <= p_in[N-1];
              r0     <= body[BODY_W-1];
              run    <= 4'd1;
              sh     <= {body[BODY_W-2:0], 1'b0};
              state  <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_end) begin
            sign_out <= sign_q;
            k_out    <= regime_k(r0, run);
            rlen_out <= regime_len(run);
            rem_out  <= (run == RUN_MAX) ? '0 : {sh[BODY_W-2:0], 1'b0};
`ifdef REGDEC16_SPECIAL_EN
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
`endif
            state    <= DONE;
          end else begin
            run <= run + 4'd1;
            sh  <= {sh[BODY_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regdec16.sv
// Self-checking bench for regdec16: directed corner words, backpressure,
// mid-scan reset and random words against a bit-counting reference model.
module tb_regdec16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [4:0]  k_out;
  logic [3:0]  rlen_out;
  logic [14:0] rem_out;
  logic        zero_out;
  logic        nar_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        sign;
    logic [4:0]  k;
    logic [3:0]  rlen;
    logic [14:0] rem;
    logic        zero;
    logic        nar;
  } exp_t;

  exp_t prev;

  regdec16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .k_out     (k_out),
    .rlen_out  (rlen_out),
    .rem_out   (rem_out),
    .zero_out  (zero_out),
    .nar_out   (nar_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Reference: count the leading run of identical body bits directly.
  function automatic exp_t model(input logic [15:0] p);
    exp_t        e;
    logic [15:0] mag;
    logic [14:0] body;
    int          m;
    mag    = p[15] ? (16'h0000 - p) : p;
    body   = mag[14:0];
    e      = '0;
    e.sign = p[15];
`ifdef REGDEC16_SPECIAL_EN
    if (p == 16'h0000 || p == 16'h8000) begin
      e.zero = (p == 16'h0000);
      e.nar  = (p == 16'h8000);
      return e;
    end
`endif
    m = 1;
    while (m < 15 && body[14-m] == body[14]) m++;
    e.k    = 5'(body[14] ? (m - 1) : -m);
    e.rlen = 4'((m + 1 > 15) ? 15 : m + 1);
    e.rem  = (m >= 15) ? 15'd0 : 15'(body << (m + 1));
    return e;
  endfunction

  function automatic int model_lat(input logic [15:0] p);
    logic [15:0] mag;
    logic [14:0] body;
    int          m;
`ifdef REGDEC16_SPECIAL_EN
    if (p == 16'h0000 || p == 16'h8000) return 1;
`endif
    mag  = p[15] ? (16'h0000 - p) : p;
    body = mag[14:0];
    m = 1;
    while (m < 15 && body[14-m] == body[14]) m++;
    return m + 1;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({sign_out, k_out, rlen_out, rem_out, zero_out, nar_out});
  endfunction

  task automatic run_word(input string tag, input logic [15:0] p, input int hold);
    exp_t e;
    int   lat;
    e = model(p);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    p_in     = p;
    @(negedge clk);
    in_valid = 1'b0;
    p_in     = 16'($urandom);
    lat      = 1;
    if (!out_valid) check({tag, ".hold_prev"}, outs(), 32'(prev));
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(model_lat(p)));
    check({tag, ".result"}, outs(), 32'(e));
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".stall_result"}, outs(), 32'(e));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".released"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({tag, ".kept_after"}, outs(), 32'(e));
    prev = e;
  endtask

  initial begin
    logic [15:0] rw;
    int          seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; p_in = 16'h0;
    prev = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.outs", outs(), 32'd0);
    check("reset.flags", {30'd0, out_valid, in_ready}, 32'd1);

    run_word("w5a00", 16'h5A00, 0);
    run_word("w7fff", 16'h7FFF, 0);
    run_word("w0001", 16'h0001, 0);
    run_word("wc000", 16'hC000, 0);
    run_word("w0000", 16'h0000, 0);
    run_word("w8000", 16'h8000, 0);
    run_word("bp4000", 16'h4000, 5);

    // Reset during a long scan discards the word.
    check("rst_scan.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    p_in     = 16'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_scan.outs", outs(), 32'd0);
    check("rst_scan.flags", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_scan.no_valid", 32'(seen), 32'd0);
    prev = '0;

    for (int i = 0; i < 30; i++) begin
      rw = 16'($urandom);
      run_word($sformatf("rand%0d", i), rw, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regdec16.md
REGDEC16 -- requirements
Module: regdec16

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, upstream offers a posit word.
REQ-004 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-005 SHALL have port p_in, input, 16, posit<16,es> bitstring; sign in bit 15.
REQ-006 SHALL have port out_valid, output, 1, decoded result available.
REQ-007 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-008 SHALL have port sign_out, output, 1, sign bit of the accepted word.
REQ-009 SHALL have port k_out, output, 5, signed regime value, range -15..+14.
REQ-010 SHALL have port rlen_out, output, 4, regime length: run plus terminator, saturated at 15.
REQ-011 SHALL have port rem_out, output, 15, bits following the regime, left-aligned, zero-filled.
REQ-012 SHALL have ports zero_out and nar_out, output, 1 each, special-value flags.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE; in_ready = 1 only in IDLE.
REQ-014 On in_valid & in_ready, SHALL latch sign = p_in[15] and body = (two's-complement magnitude of p_in)[14:0], set r0 = body[14], run = 1, shift register sh = body << 1, and enter SCAN.
REQ-015 In SCAN, SHALL terminate when run == 15 or sh[14] != r0; otherwise SHALL do run += 1, sh <<= 1 and stay in SCAN.
REQ-016 On termination, SHALL register the following values and enter DONE:
- k = r0 ? run-1 : -run
- rlen = min(run+1, 15)
- rem = (run == 15) ? 0 : sh << 1
REQ-017 Latency: a word with run length m accepted in cycle T SHALL give out_valid high in cycle T+m+1 (maximum 16).
REQ-018 In DONE, SHALL hold out_valid and all result outputs stable until out_ready is sampled high, then return to IDLE.
REQ-019 SHALL NOT accept a new word in the cycle it leaves DONE; the next accept is earliest one cycle later.
REQ-020 Outside DONE, out_valid SHALL be 0; result outputs hold their last values.

Reset
REQ-021 rst SHALL force IDLE and clear these outputs to 0: out_valid, sign_out, k_out, rlen_out, rem_out, zero_out, nar_out; in_ready is 1 the cycle after.
REQ-022 Reset asserted in SCAN or DONE SHALL discard the in-flight word; no out_valid is produced for it.

Configuration
REQ-023 Macro REGDEC16_SPECIAL_EN is the only compile-time option.
REQ-024 With REGDEC16_SPECIAL_EN defined:
- p_in = 0x0000 SHALL skip SCAN and reach DONE at T+1 with zero_out = 1, k = 0, rlen = 0, rem = 0.
- p_in = 0x8000 SHALL do the same with nar_out = 1.
REQ-025 Without REGDEC16_SPECIAL_EN:
- zero_out and nar_out SHALL be tied 0.
- 0x0000 and 0x8000 SHALL scan normally: k = -15, rlen = 15, rem = 0, latency 16.

Structure
REQ-026 Shared package (posit16_pkg) SHALL hold the FSM state enum, N = 16, the K/RLEN widths and the 0x0000/0x8000 special constants.
REQ-027 Posit negation SHALL be a sub-module posit16_abs: combinational, 16-bit in, 16-bit out; reusable by the encoder path.

Verification
REQ-028 p_in = 0x5A00 -> sign 0, k = 0, rlen = 2, rem = 0x6800, out_valid at T+2.
REQ-029 p_in = 0x7FFF -> k = +14, rlen = 15, rem = 0, out_valid at T+16.
REQ-030 p_in = 0x0001 -> k = -14, rlen = 15, rem = 0, out_valid at T+15; p_in = 0xC000 -> sign 1, k = 0, rlen = 2, rem = 0.
REQ-031 Backpressure: 0x4000 accepted, out_ready held 0 for 5 cycles -> outputs stable throughout, in_ready = 0 throughout; one cycle after out_ready = 1, in_ready = 1.
REQ-032 rst pulsed at T+5 while scanning 0x7FFF -> no out_valid; all outputs 0; IDLE at T+6.
REQ-033 p_in = 0x8000 -> with macro: nar_out = 1 at T+1; without macro: k = -15 at T+16.
